// File: rtl/text_overlay_pkg.sv
// Shared constants and width helper for the scrolling text overlay.
// Mode and direction encodings are used by both the controller and the top level.
package text_overlay_pkg;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_SCROLL = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/text_scroll_ctrl.sv
// Per-frame animation state: scroll offset, bounce direction, frame divider and blink.
// Valid/ready does not apply here; frame_tick is a single-cycle strobe.
module text_scroll_ctrl
    import text_overlay_pkg::*;
#(
    parameter int TEXT_W       = 46,
    parameter int WIN_W        = 46,
    parameter int FRAME_DIV    = 4,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_tick,
    input  logic [1:0]                  mode,
    output logic [cnt_w(TEXT_W)-1:0]    offset,
    output logic                        blink_phase
);

    localparam int OW = cnt_w(TEXT_W);
    localparam int DW = cnt_w(FRAME_DIV);
    localparam int BW = cnt_w(BLINK_FRAMES);

    localparam logic [OW-1:0] OFF_LAST   = OW'(TEXT_W - 1);
    localparam logic [OW-1:0] OFF_MAX    = OW'(TEXT_W - WIN_W);
    localparam logic [DW-1:0] DIV_LAST   = DW'(FRAME_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [OW-1:0] offset_q, offset_d;
    logic          dir_q, dir_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_phase_q;
    logic [1:0]    mode_q;

    logic mode_change;
    logic step;

    assign mode_change = (mode != mode_q);
    assign step        = frame_tick && (div_q == DIV_LAST);

    always_comb begin
        offset_d = offset_q;
        dir_d    = dir_q;
        div_d    = div_q;
        // A mode change wins over any step landing in the same cycle.
        if (mode_change) begin
            if (mode != MODE_FREEZE) begin
                offset_d = '0;
                dir_d    = DIR_FWD;
                div_d    = '0;
            end
        end else begin
            if (frame_tick && (mode != MODE_FREEZE)) begin
                div_d = step ? '0 : div_q + 1'b1;
            end
            case (mode)
                MODE_STATIC: begin
                    offset_d = '0;
                    dir_d    = DIR_FWD;
                end
                MODE_SCROLL: begin
                    if (step) begin
                        offset_d = (offset_q == OFF_LAST) ? '0 : offset_q + 1'b1;
                    end
                end
                MODE_BOUNCE: begin
                    // With no slack between window and bitmap the banner stays put.
                    if (step && (OFF_MAX != '0)) begin
                        if (dir_q == DIR_FWD) begin
                            offset_d = offset_q + 1'b1;
                            if (offset_q + 1'b1 == OFF_MAX) dir_d = DIR_REV;
                        end else begin
                            offset_d = offset_q - 1'b1;
                            if (offset_q == OW'(1)) dir_d = DIR_FWD;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            offset_q      <= '0;
            dir_q         <= DIR_FWD;
            div_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            mode_q        <= MODE_STATIC;
        end else begin
            offset_q <= offset_d;
            dir_q    <= dir_d;
            div_q    <= div_d;
            mode_q   <= mode;
            if (frame_tick) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
        end
    end

    assign offset      = offset_q;
    assign blink_phase = blink_phase_q;

endmodule

// File: rtl/text_overlay_scroll.sv
// Bitmap text overlay with a scrolling/bouncing window and frame-rate blink.
// Beam position in, registered pixel-on flag out one cycle later.
module text_overlay_scroll
    import text_overlay_pkg::*;
#(
    parameter int TEXT_W       = 46,
    parameter int TEXT_H       = 9,
    parameter int WIN_W        = 46,
    parameter int CELL_SHIFT   = 3,
    parameter int ORIGIN_X     = 18,
    parameter int ORIGIN_Y     = 12,
    parameter int FRAME_DIV    = 4,
    parameter int BLINK_FRAMES = 32,
    parameter logic [TEXT_W*TEXT_H-1:0] BITMAP = {
        46'h0F0F_0F0F_0F0F, 46'h0, 46'h0F0F_0F0F_0F0F, 46'h0,
        46'h0F0F_0F0F_0F0F, 46'h0, 46'h0F0F_0F0F_0F0F, 46'h0,
        46'h0F0F_0F0F_0F0F}
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       frame_tick,
    input  logic [1:0] mode,
    input  logic       blink_en,
    output logic       overlay_active
);

    localparam int OW = cnt_w(TEXT_W);
    localparam int SW = OW + 1;
    localparam int RW = cnt_w(TEXT_H);
    localparam int IW = cnt_w(TEXT_W * TEXT_H);

    // Window bounds in pixels; comparing unshifted values keeps the left/top edges exact.
    localparam logic [10:0] X_LO = 11'(ORIGIN_X << CELL_SHIFT);
    localparam logic [10:0] X_HI = 11'((ORIGIN_X + WIN_W) << CELL_SHIFT);
    localparam logic [10:0] Y_LO = 11'(ORIGIN_Y << CELL_SHIFT);
    localparam logic [10:0] Y_HI = 11'((ORIGIN_Y + TEXT_H) << CELL_SHIFT);
    localparam logic [SW-1:0] TW_S = SW'(TEXT_W);

    logic [OW-1:0] offset;
    logic          blink_phase;

    text_scroll_ctrl #(
        .TEXT_W       (TEXT_W),
        .WIN_W        (WIN_W),
        .FRAME_DIV    (FRAME_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .mode        (mode),
        .offset      (offset),
        .blink_phase (blink_phase)
    );

    logic [10:0]   xe, ye;
    logic          visible;
    logic [OW-1:0] cx;
    logic [RW-1:0] cy;
    logic [SW-1:0] col_sum;
    logic [OW-1:0] col;
    logic [IW-1:0] bit_idx;
    logic          pixel;

    assign xe      = {1'b0, x};
    assign ye      = {1'b0, y};
    assign visible = (xe >= X_LO) && (xe < X_HI) && (ye >= Y_LO) && (ye < Y_HI);
    assign cx      = OW'((xe - X_LO) >> CELL_SHIFT);
    assign cy      = RW'((ye - Y_LO) >> CELL_SHIFT);

    // cx and offset are both below TEXT_W, so one conditional subtract wraps the column.
    assign col_sum = {1'b0, cx} + {1'b0, offset};
    assign col     = (col_sum >= TW_S) ? OW'(col_sum - TW_S) : OW'(col_sum);
    assign bit_idx = IW'(cy) * IW'(TEXT_W) + IW'(col);
    assign pixel   = visible && BITMAP[bit_idx] && !(blink_en && blink_phase);

    always_ff @(posedge clk) begin
        if (rst) begin
            overlay_active <= 1'b0;
        end else begin
            overlay_active <= pixel;
        end
    end

endmodule

// File: tb/tb_text_overlay_scroll.sv
// Directed bench for text_overlay_scroll: a full-window instance (A) and a WIN_W=40 instance (B).
// Probes push expected pixels into a queue; a monitor pops one per registered output.
module tb_text_overlay_scroll;
    import text_overlay_pkg::*;

    // Even rows: cols c%8<4 lit for c<44; odd rows dark.
    localparam logic [45:0]  ROW_EVEN = 46'h0F0F_0F0F_0F0F;
    localparam logic [45:0]  ROW_ODD  = 46'h0;
    localparam logic [413:0] BM = {ROW_EVEN, ROW_ODD, ROW_EVEN, ROW_ODD, ROW_EVEN,
                                   ROW_ODD, ROW_EVEN, ROW_ODD, ROW_EVEN};

    logic       clk;
    logic       rst;
    logic [9:0] x, y;
    logic       ft_a, ft_b;
    logic [1:0] mode_a, mode_b;
    logic       blink_en;
    logic       ov_a, ov_b;

    logic [1:0] exp_q[$];
    string      name_q[$];
    bit         req, req_d;
    int         n_cmp = 0;
    int         n_bad = 0;

    text_overlay_scroll #(.BITMAP(BM)) dut_a (
        .clk(clk), .rst(rst), .x(x), .y(y), .frame_tick(ft_a),
        .mode(mode_a), .blink_en(blink_en), .overlay_active(ov_a)
    );

    text_overlay_scroll #(.WIN_W(40), .BITMAP(BM)) dut_b (
        .clk(clk), .rst(rst), .x(x), .y(y), .frame_tick(ft_b),
        .mode(mode_b), .blink_en(blink_en), .overlay_active(ov_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor
    always @(posedge clk) req_d <= req;

    always @(negedge clk) begin
        if (req_d) begin
            logic [1:0] e;
            logic       act;
            string      nm;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: queue empty, got %0b", ov_a);
            end else begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = e[1] ? ov_b : ov_a;
                if (act !== e[0]) begin
                    n_bad++;
                    $display("FAIL %s: overlay_active=%0b expected %0b", nm, act, e[0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic probe(input bit dut, input logic [9:0] px, input logic [9:0] py,
                         input bit e, input string nm);
        @(negedge clk);
        x = px;
        y = py;
        req = 1'b1;
        exp_q.push_back({dut, e});
        name_q.push_back(nm);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic tick(input bit dut, input int n);
        repeat (n) begin
            @(negedge clk);
            if (dut) ft_b = 1'b1;
            else     ft_a = 1'b1;
            @(negedge clk);
            ft_a = 1'b0;
            ft_b = 1'b0;
        end
    endtask

    // Row-0 scan of the first 8 window cells identifies the current offset.
    task automatic check_offset(input bit dut, input int off, input string nm);
        for (int cx = 0; cx < 8; cx++) begin
            int col;
            col = off + cx;
            if (col >= 46) col -= 46;
            probe(dut, 10'((18 + cx) * 8), 10'd96, ROW_EVEN[col], $sformatf("%s_cx%0d", nm, cx));
        end
    endtask

    task automatic set_mode(input bit dut, input logic [1:0] m);
        @(negedge clk);
        if (dut) mode_b = m;
        else     mode_a = m;
        @(negedge clk);
    endtask

    // Watchdog
    initial begin
        #400000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: time limit reached, %0d probes pending", exp_q.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Stimulus
    initial begin
        rst = 1'b1; x = '0; y = '0; ft_a = 1'b0; ft_b = 1'b0;
        mode_a = MODE_STATIC; mode_b = MODE_STATIC; blink_en = 1'b0; req = 1'b0;
        repeat (3) @(negedge clk);
        probe(1'b0, 10'd144, 10'd96, 1'b0, "reset_out_a");
        @(negedge clk);
        rst = 1'b0;

        // Static lookups and window edges
        probe(1'b0, 10'd144, 10'd96,  1'b1, "static_origin");
        probe(1'b0, 10'd143, 10'd96,  1'b0, "static_left_of_origin");
        probe(1'b0, 10'd176, 10'd96,  1'b0, "static_col4");
        probe(1'b0, 10'd144, 10'd95,  1'b0, "static_above_origin");
        probe(1'b0, 10'd512, 10'd96,  1'b0, "static_cx46");
        probe(1'b0, 10'd488, 10'd96,  1'b1, "static_col43");
        probe(1'b0, 10'd144, 10'd104, 1'b0, "static_row1");
        probe(1'b0, 10'd144, 10'd160, 1'b1, "static_row8");
        probe(1'b0, 10'd144, 10'd168, 1'b0, "static_row9");

        // Bounce with zero slack stays at offset 0
        set_mode(1'b0, MODE_BOUNCE);
        tick(1'b0, 8);
        check_offset(1'b0, 0, "bounce_max0");

        // Scroll
        set_mode(1'b0, MODE_SCROLL);
        tick(1'b0, 3);
        probe(1'b0, 10'd168, 10'd96, 1'b1, "scroll_3tick_col3");
        tick(1'b0, 1);
        probe(1'b0, 10'd168, 10'd96, 1'b0, "scroll_4tick_col4");
        check_offset(1'b0, 1, "scroll_off1");
        tick(1'b0, 176);
        check_offset(1'b0, 45, "scroll_off45");
        tick(1'b0, 4);
        check_offset(1'b0, 0, "scroll_wrap");
        probe(1'b0, 10'd488, 10'd96, 1'b1, "scroll_wrap_col43");

        // Freeze at offset 3
        tick(1'b0, 12);
        check_offset(1'b0, 3, "scroll_off3");
        set_mode(1'b0, MODE_FREEZE);
        tick(1'b0, 100);
        check_offset(1'b0, 3, "freeze_hold");

        // Blink from a fresh reset
        @(negedge clk);
        rst = 1'b1;
        mode_a = MODE_STATIC;
        @(negedge clk);
        rst = 1'b0;
        blink_en = 1'b1;
        tick(1'b0, 31);
        probe(1'b0, 10'd144, 10'd96, 1'b1, "blink_tick31");
        tick(1'b0, 1);
        probe(1'b0, 10'd144, 10'd96, 1'b0, "blink_tick32");
        blink_en = 1'b0;
        probe(1'b0, 10'd144, 10'd96, 1'b1, "blink_en_off");
        blink_en = 1'b1;
        tick(1'b0, 31);
        probe(1'b0, 10'd144, 10'd96, 1'b0, "blink_tick63");
        tick(1'b0, 1);
        probe(1'b0, 10'd144, 10'd96, 1'b1, "blink_tick64");
        blink_en = 1'b0;

        // Bounce with WIN_W=40 (max offset 6)
        set_mode(1'b1, MODE_BOUNCE);
        tick(1'b1, 4);
        check_offset(1'b1, 1, "bounce_fwd1");
        tick(1'b1, 20);
        check_offset(1'b1, 6, "bounce_max");
        probe(1'b1, 10'd440, 10'd96, 1'b1, "bounce_cx37");
        probe(1'b1, 10'd464, 10'd96, 1'b0, "bounce_cx40_hidden");
        tick(1'b1, 4);
        check_offset(1'b1, 5, "bounce_rev");
        tick(1'b1, 20);
        check_offset(1'b1, 0, "bounce_back0");
        tick(1'b1, 4);
        check_offset(1'b1, 1, "bounce_fwd_again");

        // Mode change coinciding with a step tick
        tick(1'b1, 3);
        @(negedge clk);
        mode_b = MODE_SCROLL;
        ft_b = 1'b1;
        @(negedge clk);
        ft_b = 1'b0;
        check_offset(1'b1, 0, "mode_chg_prio");
        tick(1'b1, 3);
        check_offset(1'b1, 0, "mode_chg_div_clr");
        tick(1'b1, 1);
        check_offset(1'b1, 1, "scroll_after_chg");

        // Reset mid-scroll at offset 17 with blink phase high
        set_mode(1'b0, MODE_SCROLL);
        tick(1'b0, 252);
        check_offset(1'b0, 17, "scroll_off17");
        blink_en = 1'b1;
        probe(1'b0, 10'd144, 10'd96, 1'b0, "pre_reset_blinked");
        @(negedge clk);
        rst = 1'b1;
        ft_a = 1'b1;
        x = 10'd144;
        y = 10'd96;
        req = 1'b1;
        exp_q.push_back({1'b0, 1'b0});
        name_q.push_back("reset_mid_out");
        @(negedge clk);
        rst = 1'b0;
        ft_a = 1'b0;
        req = 1'b0;
        probe(1'b0, 10'd144, 10'd96, 1'b1, "reset_blink_phase");
        blink_en = 1'b0;
        check_offset(1'b0, 0, "reset_offset");
        tick(1'b0, 3);
        check_offset(1'b0, 0, "reset_div");
        tick(1'b0, 1);
        check_offset(1'b0, 1, "reset_then_step");

        // Report
        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d probes left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
